// File: rtl/display_scanner.sv
`default_nettype none
// ============================================================================
// display_scanner : 8-digit multiplexed 7-segment driver with an iterative
//                   binary-to-BCD converter.  Revision 1.0
// ============================================================================
module display_scanner #(
    parameter int bits        = 8,
    parameter int REFRESH_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] value,
    input  logic [7:0]      anodo_mask,
    output logic [7:0]      an,
    output logic [6:0]      seg,
    output logic            busy
);

    localparam int STEP_W = $clog2(bits + 1);
    localparam int SCAN_W = $clog2(REFRESH_DIV);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(bits - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [bits-1:0]   bin;
    logic [bits-1:0]   snap;
    logic [bits-1:0]   shown;
    logic [31:0]       bcd;
    logic [31:0]       bcd_adj;
    logic [31:0]       digits;
    logic [STEP_W-1:0] step;
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        idx;
    logic [7:0]        blank;
    logic              lit;
    logic [3:0]        cur;
    logic [6:0]        seg_next;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (value != shown) state_next = SHIFT;
            SHIFT:   if (step == LAST_STEP) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 8; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // snap keeps the captured operand because bin is consumed by the shifts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin    <= '0;
            snap   <= '0;
            shown  <= '0;
            bcd    <= '0;
            digits <= '0;
            step   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (value != shown) begin
                        bin  <= value;
                        snap <= value;
                        bcd  <= '0;
                        step <= '0;
                    end
                end
                SHIFT: begin
                    bcd  <= {bcd_adj[30:0], bin[bits-1]};
                    bin  <= {bin[bits-2:0], 1'b0};
                    step <= step + 1'b1;
                end
                COMMIT: begin
                    digits <= bcd;
                    shown  <= snap;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // A digit is blank when it and every digit to its left are zero
    always_comb begin
        lit   = 1'b0;
        blank = '0;
        for (int i = 7; i >= 0; i--) begin
            lit      = lit | (digits[4*i +: 4] != 4'd0);
            blank[i] = !lit && (i != 0);
        end
    end

    always_comb begin
        cur = digits[4*idx +: 4];
        case (cur)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            default: seg_next = 7'h7F;
        endcase
        if (blank[idx])
            seg_next = 7'h7F;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an  <= 8'hFF;
            seg <= 7'h7F;
        end else begin
            an  <= ~({7'd0, ~anodo_mask[idx]} << idx);
            seg <= seg_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scanner.sv
`default_nettype none
// ============================================================================
// tb_display_scanner : scoreboard bench for display_scanner (bits 8 and 16).
// Revision 1.0
// ============================================================================
module tb_display_scanner;

    localparam logic [6:0] S0 = 7'h40, S2 = 7'h24, S3 = 7'h30, S5 = 7'h12;
    localparam logic [6:0] S6 = 7'h02, S7 = 7'h78, S9 = 7'h10, BL = 7'h7F;

    logic        clk;
    logic        rst;
    logic [7:0]  value0;
    logic [15:0] value1;
    logic [7:0]  mask0, mask1;
    logic [7:0]  an_v  [2];
    logic [6:0]  seg_v [2];
    logic [1:0]  busy_v;

    display_scanner #(.bits(8), .REFRESH_DIV(4)) dut0 (
        .clk(clk), .rst(rst), .value(value0), .anodo_mask(mask0),
        .an(an_v[0]), .seg(seg_v[0]), .busy(busy_v[0])
    );

    display_scanner #(.bits(16), .REFRESH_DIV(4)) dut1 (
        .clk(clk), .rst(rst), .value(value1), .anodo_mask(mask1),
        .an(an_v[1]), .seg(seg_v[1]), .busy(busy_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         d;
        int         slot;
        logic [7:0] an;
        logic [6:0] seg;
    } exp_t;

    exp_t fq[$];
    int   bq0[$];
    int   bq1[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   k;
    int   run0 = 0;
    int   run1 = 0;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Expected frame: slot i shows segs[7*i+:7]; anode low only if enabled
    task automatic push_frame(input int d, input logic [7:0] mask, input logic [55:0] segs);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.d    = d;
            e.slot = i;
            e.an   = 8'hFF;
            if (!mask[i]) e.an[i] = 1'b0;
            e.seg  = segs[7*i +: 7];
            fq.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (fq.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (fq.size() > 0) begin
            fail("frame_timeout");
            fq.delete();
        end
    endtask

    task automatic wait_done(input int d);
        int n = 0;
        while (busy_v[d] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (busy_v[d] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail("busy_timeout");
    endtask

    // Cycles since reset release: outputs after edge k show slot ((k-1)/4)%8
    always @(posedge clk or negedge rst) begin
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    always @(negedge clk) begin
        if (rst && k >= 1 && ((k - 1) % 4) == 2 && fq.size() > 0) begin
            if (fq[0].slot == ((k - 1) / 4) % 8) begin
                mon_e = fq.pop_front();
                check($sformatf("an_d%0d_slot%0d", mon_e.d, mon_e.slot), 32'(an_v[mon_e.d]), 32'(mon_e.an));
                check($sformatf("seg_d%0d_slot%0d", mon_e.d, mon_e.slot), 32'(seg_v[mon_e.d]), 32'(mon_e.seg));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            run0 = 0;
            run1 = 0;
        end else begin
            if (busy_v[0]) run0++;
            else if (run0 != 0) begin
                if (bq0.size() == 0) check("busy_extra_d0", run0, 0);
                else                 check("busy_len_d0", run0, bq0.pop_front());
                run0 = 0;
            end
            if (busy_v[1]) run1++;
            else if (run1 != 0) begin
                if (bq1.size() == 0) check("busy_extra_d1", run1, 0);
                else                 check("busy_len_d1", run1, bq1.pop_front());
                run1 = 0;
            end
        end
    end

    initial begin
        rst    = 1'b0;
        value0 = '0;
        value1 = '0;
        mask0  = '0;
        mask1  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_an", an_v[0], 8'hFF);
        check("rst_seg", seg_v[0], 7'h7F);
        check("rst_busy", busy_v[0], 1'b0);
        check("rst_an_d1", an_v[1], 8'hFF);
        rst = 1'b1;
        push_frame(0, 8'h00, {BL, BL, BL, BL, BL, BL, BL, S0});
        wait_drain();

        @(posedge clk); #1;
        bq0.push_back(9);
        value0 = 8'd255;
        wait_done(0);
        @(posedge clk); @(posedge clk); #1;
        push_frame(0, 8'h00, {BL, BL, BL, BL, BL, S2, S5, S5});
        wait_drain();

        @(posedge clk); #1;
        bq0.push_back(9);
        mask0  = 8'b0111_1111;
        value0 = 8'd7;
        wait_done(0);
        @(posedge clk); @(posedge clk); #1;
        push_frame(0, 8'b0111_1111, {BL, BL, BL, BL, BL, BL, BL, S7});
        wait_drain();

        @(posedge clk); #1;
        bq0.push_back(9);
        bq0.push_back(9);
        mask0  = 8'h00;
        value0 = 8'd12;
        repeat (4) @(posedge clk);
        #1 value0 = 8'd200;
        wait_done(0);
        @(negedge clk);
        check("busy_gap", busy_v[0], 1'b1);
        wait_done(0);
        @(posedge clk); @(posedge clk); #1;
        push_frame(0, 8'h00, {BL, BL, BL, BL, BL, S2, S0, S0});
        wait_drain();

        @(posedge clk); #1;
        value0 = 8'd99;
        repeat (4) @(posedge clk);
        #1;
        check("shift_busy", busy_v[0], 1'b1);
        rst = 1'b0;
        #1;
        check("abort_busy", busy_v[0], 1'b0);
        check("abort_seg", seg_v[0], 7'h7F);
        check("abort_an", an_v[0], 8'hFF);
        @(posedge clk); @(posedge clk); #1;
        bq0.push_back(9);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("busy_restart", busy_v[0], 1'b1);
        wait_done(0);
        @(posedge clk); @(posedge clk); #1;
        push_frame(0, 8'h00, {BL, BL, BL, BL, BL, BL, S9, S9});
        wait_drain();

        @(posedge clk); #1;
        bq1.push_back(17);
        value1 = 16'd65535;
        wait_done(1);
        @(posedge clk); @(posedge clk); #1;
        push_frame(1, 8'h00, {BL, BL, BL, S6, S5, S5, S3, S5});
        wait_drain();

        repeat (4) @(posedge clk);
        check("busy_pending_d0", bq0.size(), 0);
        check("busy_pending_d1", bq1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed 8-digit seven-segment driver for the calculator datapath. It consumes the operand/result value and the active-low anode mask produced by the operand-entry sequencer. It converts the binary value to decimal with an iterative double-dabble engine and scans the enabled digits at a fixed refresh rate. It is the only block that drives the board's anode and segment pins.

## Interface
- `bits`, 8: width of `value`; legal range 4..26 (result always fits 8 decimal digits).
- `REFRESH_DIV`, 100000: clock cycles each digit slot is held; minimum 2.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low (one clock; reset is asynchronous and active-low).
- `value`  in  bits  unsigned binary number to display.
- `anodo_mask`  in  8  per-digit enable, active-low (bit i = 0 enables digit i; digit 0 rightmost).
- `an`  out  8  anode drive, active-low, registered.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- Converter FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: if `value` != `shown`, capture `value` into a shift register, clear the BCD accumulator and the step count, and go to SHIFT. Otherwise stay.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by one. After `bits` steps go to COMMIT.
  - COMMIT: copy the accumulator to `digits[7:0]` (4 bits each), set `shown` to the captured value, go to IDLE.
- `value` changing during SHIFT is ignored. The snapshot completes and commits, then IDLE detects the mismatch and restarts.
- `busy` = (state != IDLE), registered with the state.
- Scan: `scan_cnt` counts 0..REFRESH_DIV-1. On wrap, `idx` advances 0→1→…→7→0.
- Digit blanking: digit i (i>0) is blank when `digits[i..7]` are all zero. Digit 0 is never blank.
- Each cycle, `an` and `seg` are registered from `idx`:
  - `an` = all ones except bit `idx`, which is 0 only if `anodo_mask[idx]` = 0.
  - `seg` = 7'h7F if blank, else the encoding of `digits[idx]`.
- Segment encodings for digits 0–9: 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000. Any nibble > 9 shows blank.
- Outputs are pure functions of registered state; there are no combinational paths from inputs to outputs.

## Timing
- Reset (`rst` low) forces the following immediately and holds them while low:
  - state IDLE, `busy` = 0
  - `digits` all 0, `shown` = 0
  - `scan_cnt` = 0, `idx` = 0
  - `an` = 8'hFF, `seg` = 7'h7F
- Conversion latency: the first edge that samples a new `value` in IDLE enters SHIFT. `bits` edges later the FSM is in COMMIT. The next edge updates `digits`, so new digits are visible `bits`+2 edges after that first sampling edge.
  - `busy` is high for exactly `bits`+1 cycles per conversion.
  - Back-to-back conversions have one cycle of `busy` low between them.
- `an`/`seg` lag `idx`/`digits` by one cycle.
- Each digit slot lasts exactly REFRESH_DIV cycles. A full frame lasts 8×REFRESH_DIV cycles.
- Reset asserted mid-conversion aborts it. After release with an unchanged nonzero `value`, conversion restarts from IDLE on the first edge.

## Test plan
(All scenarios run with REFRESH_DIV = 4.)
- Reset: `rst` low → `an` = FF, `seg` = 7F, `busy` = 0. After release with `value` = 0 and `anodo_mask` = 00 → slot 0 shows `seg` = 1000000; slots 1–7 show 1111111.
- `bits` = 8, `value` = 255 → `busy` high for 9 cycles; digits 2,5,5. Slot 2 `seg` = 0100100, slots 0/1 = 0010010, slot 3 blank.
- `anodo_mask` = 8'b0111_1111, `value` = 7 → `an` goes low only as 8'b0111_1111 during slot 7. In every other slot `an` = FF. Slot 7 `seg` = 1111111 (leading blank).
- `value` = 12, then 200 three cycles into SHIFT → digits commit 1,2. `busy` drops one cycle, then a second conversion commits 2,0,0.
- `rst` pulsed low mid-SHIFT with `value` = 99 → `busy` = 0 and digits = 0 immediately. After release, 99 is displayed 10 edges later.
- `bits` = 16, `value` = 65535 → `busy` high for 17 cycles; digits 6,5,5,3,5; slots 5–7 blank.
